// File: rtl/mips.sv
// Switch/key calculator with LED and 7-segment display, plus an 8N1 UART receiver.
// Define MIPS_UART_ECHO_EN to build the transmitter that echoes each received byte.
module mips #(
   parameter int BAUD_DIV = 2604,
   parameter int SCAN_DIV = 25000
) (
   input  logic        clk_in,
   input  logic        sys_rstn,
   input  logic [7:0]  dip_switch0,
   input  logic [7:0]  dip_switch1,
   input  logic [7:0]  dip_switch2,
   input  logic [7:0]  dip_switch3,
   input  logic [7:0]  dip_switch4,
   input  logic [7:0]  dip_switch5,
   input  logic [7:0]  dip_switch6,
   input  logic [7:0]  dip_switch7,
   input  logic [7:0]  user_key,
   output logic [31:0] led_light,
   output logic [7:0]  digital_tube0,
   output logic [7:0]  digital_tube1,
   output logic [7:0]  digital_tube2,
   output logic [3:0]  digital_tube_sel0,
   output logic [3:0]  digital_tube_sel1,
   output logic        digital_tube_sel2,
   input  logic        uart_rxd,
   output logic        uart_txd
);

   localparam int BW = $clog2(BAUD_DIV + 1);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic        srst;
   logic [31:0] op;
   logic [31:0] r_reg, r_next;
   logic [7:0]  key_s1_reg, key_s2_reg, key_prev_reg, key_edge;
   logic [SW-1:0] scan_cnt_reg;
   logic [1:0]  digit_reg;
   logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
   rx_state_t   rx_state_reg, rx_state_next;
   logic [BW-1:0] rx_cnt_reg, rx_cnt_next;
   logic [2:0]  rx_bit_reg, rx_bit_next;
   logic [7:0]  rx_shift_reg, rx_shift_next;
   logic [7:0]  rxb_reg, rxb_next;
   logic        rx_valid_reg, rx_valid_next;

   assign srst = sys_rstn;
   assign op   = {dip_switch3, dip_switch2, dip_switch1, dip_switch0};

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_key_edge
         assign key_edge[gi] = key_s2_reg[gi] & ~key_prev_reg[gi];
      end
   endgenerate

   // Lowest-indexed key edge wins when several arrive together.
   always_comb begin
      r_next = r_reg;
      casez (key_edge)
         8'b???????1: r_next = op;
         8'b??????10: r_next = r_reg + op;
         8'b?????100: r_next = r_reg - op;
         8'b????1000: r_next = r_reg ^ op;
         8'b???10000: r_next = r_reg << 1;
         8'b??100000: r_next = r_reg >> 1;
         8'b?1000000: r_next = ~r_reg;
         8'b10000000: r_next = 32'h0;
         default:     r_next = r_reg;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (srst) begin
         key_s1_reg   <= '0;
         key_s2_reg   <= '0;
         key_prev_reg <= '0;
         r_reg        <= '0;
         scan_cnt_reg <= '0;
         digit_reg    <= '0;
      end else begin
         key_s1_reg   <= user_key;
         key_s2_reg   <= key_s1_reg;
         key_prev_reg <= key_s2_reg;
         r_reg        <= r_next;
         if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            digit_reg    <= digit_reg + 2'd1;
         end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
         end
      end
   end

   assign led_light         = ~r_reg;
   assign digital_tube_sel0 = 4'b0001 << digit_reg;
   assign digital_tube_sel1 = 4'b0001 << digit_reg;
   assign digital_tube_sel2 = 1'b1;
   assign digital_tube0     = hex7(r_reg[{digit_reg, 2'b00} +: 4]);
   assign digital_tube1     = hex7(r_reg[{1'b1, digit_reg, 2'b00} +: 4]);
   assign digital_tube2     = hex7(rxb_reg[3:0]);

   // A start needs a sampled high followed by low, so a stuck-low line never re-arms.
   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_cnt_reg;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rxb_next      = rxb_reg;
      rx_valid_next = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            if (rx_prev_reg && !rx_s2_reg) begin
               rx_state_next = RX_START;
               rx_cnt_next   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_reg == HALF_LAST) begin
               rx_cnt_next   = '0;
               rx_bit_next   = '0;
               rx_state_next = rx_s2_reg ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_reg == BAUD_LAST) begin
               rx_cnt_next   = '0;
               rx_shift_next = {rx_s2_reg, rx_shift_reg[7:1]};
               rx_bit_next   = rx_bit_reg + 3'd1;
               if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_reg == BAUD_LAST) begin
               rx_state_next = RX_IDLE;
               if (rx_s2_reg) begin
                  rxb_next      = rx_shift_reg;
                  rx_valid_next = 1'b1;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (srst) begin
         rx_s1_reg    <= 1'b0;
         rx_s2_reg    <= 1'b0;
         rx_prev_reg  <= 1'b0;
         rx_state_reg <= RX_IDLE;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
         rxb_reg      <= '0;
         rx_valid_reg <= 1'b0;
      end else begin
         rx_s1_reg    <= uart_rxd;
         rx_s2_reg    <= rx_s1_reg;
         rx_prev_reg  <= rx_s2_reg;
         rx_state_reg <= rx_state_next;
         rx_cnt_reg   <= rx_cnt_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
         rxb_reg      <= rxb_next;
         rx_valid_reg <= rx_valid_next;
      end
   end

   logic unused_inputs;

`ifdef MIPS_UART_ECHO_EN
   logic          tx_busy_reg;
   logic [9:0]    tx_shift_reg;
   logic [BW-1:0] tx_cnt_reg;
   logic [3:0]    tx_bit_reg;

   // Frame is {stop, data, start} shifted out LSB first; bytes arriving while busy are dropped.
   always_ff @(posedge clk_in) begin
      if (srst) begin
         tx_busy_reg  <= 1'b0;
         tx_shift_reg <= '1;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
      end else if (!tx_busy_reg) begin
         if (rx_valid_reg) begin
            tx_busy_reg  <= 1'b1;
            tx_shift_reg <= {1'b1, rxb_reg, 1'b0};
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
         end
      end else if (tx_cnt_reg == BAUD_LAST) begin
         tx_cnt_reg   <= '0;
         tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
         tx_bit_reg   <= tx_bit_reg + 4'd1;
         if (tx_bit_reg == 4'd9) tx_busy_reg <= 1'b0;
      end else begin
         tx_cnt_reg <= tx_cnt_reg + 1'b1;
      end
   end

   assign uart_txd      = tx_busy_reg ? tx_shift_reg[0] : 1'b1;
   assign unused_inputs = ^{dip_switch4, dip_switch5, dip_switch6, dip_switch7};
`else
   assign uart_txd      = 1'b1;
   assign unused_inputs = ^{dip_switch4, dip_switch5, dip_switch6, dip_switch7, rx_valid_reg};
`endif

endmodule

// File: tb/tb_mips.sv
// Self-checking bench for mips: key-operation vector table, display scan, UART receive
// (framing, glitch, stuck-low, reset abort) and, with MIPS_UART_ECHO_EN, the echo frame.
module tb_mips;
   localparam int BAUD = 16;
   localparam int SCAN = 4;
   localparam logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic        clk_in = 1'b0;
   logic        sys_rstn;
   logic [7:0]  dip_switch0, dip_switch1, dip_switch2, dip_switch3;
   logic [7:0]  dip_switch4, dip_switch5, dip_switch6, dip_switch7;
   logic [7:0]  user_key;
   logic [31:0] led_light;
   logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
   logic [3:0]  digital_tube_sel0, digital_tube_sel1;
   logic        digital_tube_sel2;
   logic        uart_rxd;
   logic        uart_txd;

   mips #(.BAUD_DIV(BAUD), .SCAN_DIV(SCAN)) dut (
      .clk_in(clk_in), .sys_rstn(sys_rstn),
      .dip_switch0(dip_switch0), .dip_switch1(dip_switch1),
      .dip_switch2(dip_switch2), .dip_switch3(dip_switch3),
      .dip_switch4(dip_switch4), .dip_switch5(dip_switch5),
      .dip_switch6(dip_switch6), .dip_switch7(dip_switch7),
      .user_key(user_key), .led_light(led_light),
      .digital_tube0(digital_tube0), .digital_tube1(digital_tube1), .digital_tube2(digital_tube2),
      .digital_tube_sel0(digital_tube_sel0), .digital_tube_sel1(digital_tube_sel1),
      .digital_tube_sel2(digital_tube_sel2),
      .uart_rxd(uart_rxd), .uart_txd(uart_txd)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0]  keys;
      logic [31:0] op;
      logic [31:0] exp_r;
   } key_vec_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_tube2;
   } rx_vec_t;

   key_vec_t    kv [13];
   rx_vec_t     rv [5];
   logic [31:0] r_q [$];
   logic [7:0]  t2_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          txd_low_cnt = 0;

   always @(negedge clk_in) if (uart_txd === 1'b0) txd_low_cnt++;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] seg(input logic [3:0] n);
      return SEG_TAB[n];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_sel(input logic [3:0] want);
      int t = 0;
      while (digital_tube_sel0 !== want && t < 64) begin
         @(negedge clk_in);
         t++;
      end
      check("sel0_reached", {28'h0, digital_tube_sel0}, {28'h0, want});
   endtask

   task automatic press(input logic [7:0] k, input logic [31:0] op);
      {dip_switch3, dip_switch2, dip_switch1, dip_switch0} = op;
      user_key = k;
      repeat (5) @(negedge clk_in);
      user_key = 8'h00;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      uart_rxd = 1'b0;
      repeat (BAUD) @(negedge clk_in);
      for (int k = 0; k < 8; k++) begin
         uart_rxd = b[k];
         repeat (BAUD) @(negedge clk_in);
      end
      uart_rxd = stop;
      repeat (BAUD) @(negedge clk_in);
      uart_rxd = 1'b1;
      repeat (2 * BAUD) @(negedge clk_in);
   endtask

   initial begin
      logic [31:0] exp_r;
      logic [7:0]  exp_t2;
      int          low0;

      kv[0]  = '{8'h01, 32'h0000_0005, 32'h0000_0005};
      kv[1]  = '{8'h02, 32'h0000_0005, 32'h0000_000A};
      kv[2]  = '{8'h04, 32'h0000_0003, 32'h0000_0007};
      kv[3]  = '{8'h08, 32'hF0F0_F0F0, 32'hF0F0_F0F7};
      kv[4]  = '{8'h10, 32'h0000_0000, 32'hE1E1_E1EE};
      kv[5]  = '{8'h20, 32'h0000_0000, 32'h70F0_F0F7};
      kv[6]  = '{8'h40, 32'h0000_0000, 32'h8F0F_0F08};
      kv[7]  = '{8'h02, 32'h70F0_F0F8, 32'h0000_0000};
      kv[8]  = '{8'h14, 32'h0000_0001, 32'hFFFF_FFFF};
      kv[9]  = '{8'h80, 32'h0000_0000, 32'h0000_0000};
      kv[10] = '{8'h01, 32'h1234_5678, 32'h1234_5678};
      kv[11] = '{8'h0A, 32'h1111_1111, 32'h2345_6789};
      kv[12] = '{8'h30, 32'h0000_0000, 32'h468A_CF12};

      rv[0] = '{8'h3C, 1'b1, 8'hC6};
      rv[1] = '{8'h77, 1'b0, 8'hC6};
      rv[2] = '{8'h5A, 1'b1, 8'h88};
      rv[3] = '{8'hF0, 1'b0, 8'h88};
      rv[4] = '{8'h01, 1'b1, 8'hF9};

      sys_rstn = 1'b1;
      uart_rxd = 1'b0;
      user_key = 8'h00;
      {dip_switch3, dip_switch2, dip_switch1, dip_switch0} = 32'h0;
      dip_switch4 = 8'($urandom);
      dip_switch5 = 8'($urandom);
      dip_switch6 = 8'($urandom);
      dip_switch7 = 8'($urandom);

      repeat (10) @(negedge clk_in);
      check("rst_led", led_light, 32'hFFFF_FFFF);
      check("rst_txd", {31'h0, uart_txd}, 32'h1);
      check("rst_tube0", {24'h0, digital_tube0}, 32'hC0);
      check("rst_tube1", {24'h0, digital_tube1}, 32'hC0);
      check("rst_tube2", {24'h0, digital_tube2}, 32'hC0);
      check("rst_sel0", {28'h0, digital_tube_sel0}, 32'h1);
      check("rst_sel1", {28'h0, digital_tube_sel1}, 32'h1);
      check("rst_sel2", {31'h0, digital_tube_sel2}, 32'h1);
      $display("reset: led=%h tube0=%h tube1=%h tube2=%h txd=%b",
               led_light, digital_tube0, digital_tube1, digital_tube2, uart_txd);

      low0 = txd_low_cnt;
      sys_rstn = 1'b0;
      repeat (500) @(negedge clk_in);
      check("stuck_low_tube2", {24'h0, digital_tube2}, 32'hC0);
      check("stuck_low_txd_quiet", 32'(txd_low_cnt - low0), 32'h0);
      $display("rxd held low 500 cycles: tube2=%h", digital_tube2);
      uart_rxd = 1'b1;
      repeat (20) @(negedge clk_in);

      for (int i = 0; i < 13; i++) begin
         r_q.push_back(kv[i].exp_r);
         press(kv[i].keys, kv[i].op);
         exp_r = r_q.pop_front();
         check("key_led", led_light, ~exp_r);
         wait_sel(4'b0001);
         check("key_tube0_digit0", {24'h0, digital_tube0}, {24'h0, seg(exp_r[3:0])});
         $display("key vec %0d keys=%h op=%h led=%h expected R=%h", i, kv[i].keys, kv[i].op,
                  led_light, exp_r);
      end

      for (int d = 0; d < 4; d++) begin
         wait_sel(4'(1 << d));
         check("scan_tube0", {24'h0, digital_tube0}, {24'h0, seg(exp_r[4*d +: 4])});
         check("scan_tube1", {24'h0, digital_tube1}, {24'h0, seg(exp_r[16 + 4*d +: 4])});
         check("scan_sel1", {28'h0, digital_tube_sel1}, {28'h0, digital_tube_sel0});
         $display("scan digit %0d: tube0=%h tube1=%h", d, digital_tube0, digital_tube1);
      end

      for (int i = 0; i < 5; i++) begin
         t2_q.push_back(rv[i].exp_tube2);
         send_frame(rv[i].data, rv[i].stop);
         exp_t2 = t2_q.pop_front();
         check("rx_tube2", {24'h0, digital_tube2}, {24'h0, exp_t2});
         $display("rx frame %0d data=%h stop=%b tube2=%h", i, rv[i].data, rv[i].stop, digital_tube2);
      end

      uart_rxd = 1'b0;
      repeat (4) @(negedge clk_in);
      uart_rxd = 1'b1;
      repeat (3 * BAUD) @(negedge clk_in);
      check("glitch_tube2", {24'h0, digital_tube2}, 32'hF9);
      $display("short start glitch: tube2=%h", digital_tube2);

`ifdef MIPS_UART_ECHO_EN
      fork
         send_frame(8'hA5, 1'b1);
         begin : echo_watch
            logic [9:0] echo_bits;
            int t;
            echo_bits = {1'b1, 8'hA5, 1'b0};
            t = 0;
            while (uart_txd === 1'b1 && t < 400) begin
               @(negedge clk_in);
               t++;
            end
            check("echo_start_seen", {31'h0, uart_txd}, 32'h0);
            repeat (BAUD / 2) @(negedge clk_in);
            for (int k = 0; k < 10; k++) begin
               check("echo_bit", {31'h0, uart_txd}, {31'h0, echo_bits[k]});
               $display("echo bit %0d: txd=%b expected %b", k, uart_txd, echo_bits[k]);
               repeat (BAUD) @(negedge clk_in);
            end
         end
      join
`else
      low0 = txd_low_cnt;
      send_frame(8'hA5, 1'b1);
      repeat (12 * BAUD) @(negedge clk_in);
      check("no_echo_txd_quiet", 32'(txd_low_cnt - low0), 32'h0);
      $display("no echo build: txd low samples=%0d", txd_low_cnt - low0);
`endif
      check("a5_tube2", {24'h0, digital_tube2}, 32'h92);

      uart_rxd = 1'b0;
      repeat (4 * BAUD) @(negedge clk_in);
      sys_rstn = 1'b1;
      uart_rxd = 1'b1;
      repeat (3) @(negedge clk_in);
      sys_rstn = 1'b0;
      repeat (14 * BAUD) @(negedge clk_in);
      check("midframe_rst_tube2", {24'h0, digital_tube2}, 32'hC0);
      check("midframe_rst_led", led_light, 32'hFFFF_FFFF);
      check("midframe_rst_txd", {31'h0, uart_txd}, 32'h1);
      $display("reset mid-frame: tube2=%h led=%h", digital_tube2, led_light);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
